sw_top: RTL and testbench

// Streaming banded Smith-Waterman local-alignment scorer. Pops one 4-bit symbol pair per

---
 rtl/sw_top.sv | 120 ++++++++++++
 tb/tb_sw_top.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_top.sv
// Streaming banded Smith-Waterman scorer: pops one ref/read symbol pair per cycle and
// tracks the three-diagonal band (|i-j|<=1), reporting the best local score per alignment.
module sw_top #(
    parameter int SEQ_LEN  = 63,
    parameter int SYM_W    = 4,
    parameter int SCORE_W  = 10,
    parameter int MATCH    = 2,
    parameter int MISMATCH = 1,
    parameter int GAP      = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               buf1_empty,
    input  logic               buf2_empty,
    input  logic [SYM_W-1:0]   buf1_out,
    input  logic [SYM_W-1:0]   buf2_out,
    output logic               rd1_en,
    output logic               rd2_en,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         o_dbg_state
);
    localparam int SW = SCORE_W + 2;
    localparam int KW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

    typedef logic signed [SW-1:0] sc_t;

    localparam sc_t C_MATCH    = sc_t'(MATCH);
    localparam sc_t C_MISMATCH = sc_t'(MISMATCH);
    localparam sc_t C_GAP      = sc_t'(GAP);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    // Handshake: a pair is consumed on a rising edge where rd1_en (== rd2_en) is high;
    // that happens whenever both FIFOs show data and the scorer is not in its DONE gap.

    function automatic sc_t smax(input sc_t a, input sc_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic sc_t subst(input logic [SYM_W-1:0] a, input logic [SYM_W-1:0] b);
        return (a == b) ? C_MATCH : -C_MISMATCH;
    endfunction

    logic [1:0]         r_state;
    logic [KW-1:0]      r_k;
    logic [SCORE_W-1:0] r_d, r_l, r_u, r_best, r_score;
    logic [SYM_W-1:0]   r_rp, r_qp;

    logic w_pop, w_first, w_last;
    sc_t  w_d, w_l, w_u, w_hl, w_hu, w_hd, w_best_n;
    logic w_unused_hi;

    assign w_pop   = !buf1_empty && !buf2_empty && (r_state != S_DONE);
    assign w_first = (r_k == '0);
    assign w_last  = (r_k == KW'(SEQ_LEN - 1));

    always_comb begin
        w_d  = w_first ? sc_t'(0) : $signed({2'b00, r_d});
        w_l  = w_first ? sc_t'(0) : $signed({2'b00, r_l});
        w_u  = w_first ? sc_t'(0) : $signed({2'b00, r_u});
        w_hl = sc_t'(0);
        w_hu = sc_t'(0);
        if (!w_first) begin
            w_hl = smax(smax(sc_t'(0), w_l + subst(buf1_out, r_qp)), w_d - C_GAP);
            w_hu = smax(smax(sc_t'(0), w_u + subst(r_rp, buf2_out)), w_d - C_GAP);
        end
        // The diagonal cell can be reached through either off-diagonal neighbour.
        w_hd = smax(smax(sc_t'(0), w_d + subst(buf1_out, buf2_out)),
                    smax(w_hl - C_GAP, w_hu - C_GAP));
        w_best_n = smax(smax($signed({2'b00, r_best}), w_hd), smax(w_hl, w_hu));
    end

    // Scores never exceed 2*SEQ_LEN, so the guard bits above SCORE_W stay zero.
    assign w_unused_hi = ^{w_hd[SW-1:SCORE_W], w_hl[SW-1:SCORE_W],
                           w_hu[SW-1:SCORE_W], w_best_n[SW-1:SCORE_W]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_d     <= '0;
            r_l     <= '0;
            r_u     <= '0;
            r_best  <= '0;
            r_score <= '0;
            r_rp    <= '0;
            r_qp    <= '0;
        end else if (r_state == S_DONE) begin
            r_state <= S_IDLE;
        end else if (w_pop) begin
            if (w_last) begin
                r_state <= S_DONE;
                r_score <= w_best_n[SCORE_W-1:0];
                r_k     <= '0;
                r_d     <= '0;
                r_l     <= '0;
                r_u     <= '0;
                r_best  <= '0;
                r_rp    <= '0;
                r_qp    <= '0;
            end else begin
                r_state <= S_RUN;
                r_k     <= r_k + 1'b1;
                r_d     <= w_hd[SCORE_W-1:0];
                r_l     <= w_hl[SCORE_W-1:0];
                r_u     <= w_hu[SCORE_W-1:0];
                r_best  <= w_best_n[SCORE_W-1:0];
                r_rp    <= buf1_out;
                r_qp    <= buf2_out;
            end
        end
    end

    assign rd1_en      = w_pop;
    assign rd2_en      = w_pop;
    assign score       = r_score;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_sw_top.sv
// Bench for sw_top: streams symbol pairs with optional stalls and compares the reported
// score with a full banded Smith-Waterman matrix computed in the bench.
module tb_sw_top;
    localparam int N = 63;

    logic       clk = 1'b0;
    logic       rst;
    logic       b1e, b2e;
    logic [3:0] b1o, b2o;
    logic       rd1, rd2;
    logic [9:0] score;
    logic [1:0] dbg_state;

    int n_chk  = 0;
    int n_fail = 0;
    int last_score = 0;

    logic [3:0] ref_a [N];
    logic [3:0] rd_a  [N];

    sw_top dut (
        .clk        (clk),
        .rst        (rst),
        .buf1_empty (b1e),
        .buf2_empty (b2e),
        .buf1_out   (b1o),
        .buf2_out   (b2o),
        .rd1_en     (rd1),
        .rd2_en     (rd2),
        .score      (score),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] base(input int b);
        logic [3:0] one;
        one = 4'b0001;
        return one << b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Full matrix H[i][j] (offset by one), only cells with |i-j|<=1 are filled;
    // everything else stays 0, which the clamp at 0 makes harmless.
    function automatic int model_score();
        int h [N+1][N+1];
        int best;
        best = 0;
        for (int i = 0; i <= N; i++)
            for (int j = 0; j <= N; j++)
                h[i][j] = 0;
        for (int i = 0; i < N; i++) begin
            for (int j = (i > 0 ? i - 1 : 0); j <= (i < N - 1 ? i + 1 : N - 1); j++) begin
                int v;
                v = h[i][j] + ((ref_a[i] == rd_a[j]) ? 2 : -1);
                v = imax(v, h[i][j+1] - 1);
                v = imax(v, h[i+1][j] - 1);
                v = imax(v, 0);
                h[i+1][j+1] = v;
                best = imax(best, v);
            end
        end
        return best;
    endfunction

    task automatic fill_identical();
        for (int i = 0; i < N; i++) begin
            ref_a[i] = base(i % 4);
            rd_a[i]  = ref_a[i];
        end
    endtask

    task automatic run_align(input int stall_at, input int stall_len, input int stall_pct,
                             input int exp_const, input string name);
        int idx, cyc, stl, exp_s;
        bit stall, which;
        idx = 0; cyc = 0; stl = 0; which = 1'b0;
        exp_s = model_score();
        while (idx < N && cyc < 2000) begin
            stall = 1'b0;
            if (idx == stall_at && stl < stall_len) begin
                stall = 1'b1;
                which = 1'b1;
                stl++;
            end else if (stall_pct > 0 && $urandom_range(0, 99) < stall_pct) begin
                stall = 1'b1;
                which = 1'($urandom_range(0, 1));
            end
            b1e = stall && !which;
            b2e = stall && which;
            b1o = ref_a[idx];
            b2o = rd_a[idx];
            #1;
            n_chk++;
            if ({rd1, rd2} !== {2{!stall}}) begin
                n_fail++;
                $display("FAIL %s rd_en idx=%0d got rd1=%b rd2=%b expected %b", name, idx, rd1, rd2, !stall);
            end
            if (idx == 40) begin
                n_chk++;
                if (score !== 10'(last_score)) begin
                    n_fail++;
                    $display("FAIL %s score_hold got %0d expected %0d", name, score, last_score);
                end
            end
            tick();
            if (!stall) idx++;
            cyc++;
        end
        b1e = 1'b1;
        b2e = 1'b1;
        n_chk++;
        if (idx != N) begin
            n_fail++;
            $display("FAIL %s timeout popped %0d expected %0d", name, idx, N);
        end
        n_chk++;
        if (score !== 10'(exp_s)) begin
            n_fail++;
            $display("FAIL %s score got %0d expected %0d", name, score, exp_s);
        end
        if (exp_const >= 0) begin
            n_chk++;
            if (score !== 10'(exp_const)) begin
                n_fail++;
                $display("FAIL %s score_const got %0d expected %0d", name, score, exp_const);
            end
        end
        // One-cycle gap after the last pop: data present but nothing popped.
        b1e = 1'b0;
        b2e = 1'b0;
        #1;
        n_chk++;
        if (rd1 !== 1'b0 || rd2 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_gap got rd1=%b rd2=%b expected 0", name, rd1, rd2);
        end
        b1e = 1'b1;
        b2e = 1'b1;
        tick();
        last_score = exp_s;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b1e = 1'b1;
        b2e = 1'b1;
        b1o = 4'b0001;
        b2o = 4'b0001;
        repeat (3) tick();
        n_chk++;
        if (score !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_score got %0d expected 0", score);
        end
        n_chk++;
        if (rd1 !== 1'b0 || rd2 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rd_en got rd1=%b rd2=%b expected 0", rd1, rd2);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_identical();
        fill_identical();
        run_align(-1, 0, 0, 126, "identical");
    endtask

    task automatic test_shift();
        fill_identical();
        rd_a[0] = base(3);
        for (int i = 1; i < N; i++) rd_a[i] = ref_a[i-1];
        run_align(-1, 0, 0, 124, "shift");
    endtask

    task automatic test_substitution();
        fill_identical();
        rd_a[31] = base(0);
        run_align(-1, 0, 0, 123, "subst");
    endtask

    task automatic test_stall();
        fill_identical();
        run_align(20, 5, 0, 126, "stall");
    endtask

    task automatic test_reset_mid();
        fill_identical();
        for (int i = 0; i < 30; i++) begin
            b1e = 1'b0;
            b2e = 1'b0;
            b1o = ref_a[i];
            b2o = rd_a[i];
            tick();
        end
        rst = 1'b1;
        b1e = 1'b1;
        b2e = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++;
        if (score !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_mid_score got %0d expected 0", score);
        end
        last_score = 0;
        run_align(-1, 0, 0, 126, "after_reset");
    endtask

    task automatic test_back_to_back();
        fill_identical();
        run_align(-1, 0, 0, 126, "b2b_first");
        for (int i = 0; i < N; i++) begin
            ref_a[i] = base(0);
            rd_a[i]  = base(1);
        end
        run_align(-1, 0, 0, 0, "b2b_mismatch");
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < N; i++) begin
                ref_a[i] = base($urandom_range(0, 3));
                rd_a[i]  = ($urandom_range(0, 9) < 2) ? base($urandom_range(0, 3)) : ref_a[i];
            end
            if (it % 3 == 2) begin
                for (int i = N - 1; i > 0; i--) rd_a[i] = rd_a[i-1];
            end
            run_align(-1, 0, 20, -1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_identical();
        test_shift();
        test_substitution();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
